// File: rtl/alu_req_arbiter_if.sv
// Bundles the requester handshakes, the response channel and the ALU strobe/result bus.
// slave = the arbiter; master = the requesters plus the ALU.
interface alu_req_arbiter_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*M-1:0] req_cmd;
    logic [1:0]     req_mode;
    logic [1:0]     req_cin;
    logic [2*N-1:0] req_opa;
    logic [2*N-1:0] req_opb;

    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [N:0]     rsp_res;
    logic [5:0]     rsp_flags;

    logic           alu_ce;
    logic           alu_mode;
    logic           alu_cin;
    logic [1:0]     alu_inp_valid;
    logic [M-1:0]   alu_cmd;
    logic [N-1:0]   alu_opa;
    logic [N-1:0]   alu_opb;
    logic [N:0]     alu_res;
    logic           alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;

    logic           busy;

    modport slave (
        input  req_valid, req_cmd, req_mode, req_cin, req_opa, req_opb,
        output req_ready,
        output rsp_valid, rsp_res, rsp_flags,
        input  rsp_ready,
        output alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb,
        input  alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
        output busy
    );

    modport master (
        output req_valid, req_cmd, req_mode, req_cin, req_opa, req_opb,
        input  req_ready,
        input  rsp_valid, rsp_res, rsp_flags,
        output rsp_ready,
        input  alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb,
        output alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
        input  busy
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: one transaction in flight,
// issue strobe, command-dependent wait, captured result returned over a response handshake.
module alu_req_arbiter #(
    parameter int N         = 8,
    parameter int M         = 4,
    parameter int LAT       = 1,
    parameter int MUL_LAT   = 2,
    parameter int MUL_CMD_A = 9,
    parameter int MUL_CMD_B = 10
) (
    input logic             CLK,
    input logic             RST,
    alu_req_arbiter_if.slave bus
);
    localparam int MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          ptr;
    logic          owner;
    logic          grant;
    logic          is_mul;
    logic [M-1:0]  cmd_q;
    logic          mode_q;
    logic          cin_q;
    logic [N-1:0]  opa_q;
    logic [N-1:0]  opb_q;
    logic [CW-1:0] cnt;
    logic [N:0]    res_q;
    logic [5:0]    flags_q;

    logic [M-1:0]  sel_cmd;
    logic          sel_mode;
    logic          sel_cin;
    logic [N-1:0]  sel_opa;
    logic [N-1:0]  sel_opb;

    // A lone requester wins outright; the pointer only breaks ties.
    assign grant    = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];
    assign sel_cmd  = grant ? bus.req_cmd[2*M-1:M] : bus.req_cmd[M-1:0];
    assign sel_mode = bus.req_mode[grant];
    assign sel_cin  = bus.req_cin[grant];
    assign sel_opa  = grant ? bus.req_opa[2*N-1:N] : bus.req_opa[N-1:0];
    assign sel_opb  = grant ? bus.req_opb[2*N-1:N] : bus.req_opb[N-1:0];
    assign is_mul   = mode_q && ((cmd_q == M'(MUL_CMD_A)) || (cmd_q == M'(MUL_CMD_B)));

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state)
            IDLE: begin
                // Gated by RST so no accept leaks out while reset is held.
                if (RST && (bus.req_valid != '0)) begin
                    bus.req_ready[grant] = 1'b1;
                    state_nxt            = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (cnt == CW'(1)) state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid[owner] = 1'b1;
                if (bus.rsp_ready[owner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req_valid != '0) begin
                        owner  <= grant;
                        cmd_q  <= sel_cmd;
                        mode_q <= sel_mode;
                        cin_q  <= sel_cin;
                        opa_q  <= sel_opa;
                        opb_q  <= sel_opb;
                    end
                end
                ISSUE: cnt <= is_mul ? CW'(MUL_LAT) : CW'(LAT);
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        res_q   <= bus.alu_res;
                        flags_q <= {bus.alu_err, bus.alu_oflow, bus.alu_cout,
                                    bus.alu_g, bus.alu_l, bus.alu_e};
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[owner]) ptr <= ~owner;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_ce        = (state == ISSUE);
    assign bus.alu_inp_valid = {2{state == ISSUE}};
    assign bus.alu_cmd       = cmd_q;
    assign bus.alu_mode      = mode_q;
    assign bus.alu_cin       = cin_q;
    assign bus.alu_opa       = opa_q;
    assign bus.alu_opb       = opb_q;
    assign bus.rsp_res       = res_q;
    assign bus.rsp_flags     = flags_q;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a vector table of single transactions plus
// hand-written sequences for contention, backpressure, reset mid-wait and streaming.
module tb_alu_req_arbiter;
    localparam int N = 8;
    localparam int M = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    alu_req_arbiter_if #(.N(N), .M(M)) bus ();

    alu_req_arbiter #(
        .N(N), .M(M), .LAT(1), .MUL_LAT(2), .MUL_CMD_A(9), .MUL_CMD_B(10)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Simple ALU stand-in: multiplies present a junk value until their latency has elapsed.
    function automatic logic [N+6:0] alu_fn(input logic [M-1:0] c, input logic md, input logic ci,
                                            input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] r;
        logic [5:0] f;
        r = '0;
        f = '0;
        if (!md) r = {1'b0, a & b};
        else begin
            case (c)
                4'd0: begin r = {1'b0, a} + {1'b0, b}; f[3] = r[N]; end
                4'd2: begin r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci}; f[3] = r[N]; end
                4'd8: begin f[2] = (a > b); f[1] = (a < b); f[0] = (a == b); end
                4'd9, 4'd10: r = {1'b0, a} * {1'b0, b};
                default: f[5] = 1'b1;
            endcase
        end
        return {f, r};
    endfunction

    logic [N:0] pend_r;
    logic [5:0] pend_f;
    int         pend_d;

    always @(posedge CLK or negedge RST) begin : alu_model
        logic [N+6:0] o;
        if (!RST) begin
            bus.alu_res <= '0;
            {bus.alu_err, bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_l, bus.alu_e} <= '0;
            pend_r <= '0;
            pend_f <= '0;
            pend_d <= 0;
        end else if (bus.alu_ce && bus.alu_inp_valid == 2'b11) begin
            o = alu_fn(bus.alu_cmd, bus.alu_mode, bus.alu_cin, bus.alu_opa, bus.alu_opb);
            if (bus.alu_mode && (bus.alu_cmd == 4'd9 || bus.alu_cmd == 4'd10)) begin
                bus.alu_res <= 9'h1AA;
                {bus.alu_err, bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_l, bus.alu_e} <= 6'b010101;
                pend_r <= o[N:0];
                pend_f <= o[N+6:N+1];
                pend_d <= 1;
            end else begin
                bus.alu_res <= o[N:0];
                {bus.alu_err, bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_l, bus.alu_e} <= o[N+6:N+1];
                pend_d <= 0;
            end
        end else if (pend_d > 0) begin
            pend_d <= pend_d - 1;
            if (pend_d == 1) begin
                bus.alu_res <= pend_r;
                {bus.alu_err, bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_l, bus.alu_e} <= pend_f;
            end
        end
    end

    typedef struct {
        int         r;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] res;
        logic [5:0] flags;
        int         lat;
        string      name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int r, input logic [3:0] c, input logic md, input logic ci,
                            input logic [7:0] a, input logic [7:0] b);
        bus.req_cmd[r*M +: M] = c;
        bus.req_mode[r]       = md;
        bus.req_cin[r]        = ci;
        bus.req_opa[r*N +: N] = a;
        bus.req_opb[r*N +: N] = b;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        bus.req_valid = 2'b00;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!bus.busy) break;
        end
        check(name, bus.busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int w;
        int ce_extra;
        w = 0;
        ce_extra = 0;
        @(negedge CLK);
        set_slot(v.r, v.cmd, v.mode, v.cin, v.a, v.b);
        set_slot(1 - v.r, 4'd15, 1'b1, 1'b1, 8'h5A, 8'hA5);
        bus.req_valid = 2'b01 << v.r;
        bus.rsp_ready = 2'b11;
        #1 check({v.name, "_ready"}, bus.req_ready, 2'b01 << v.r);
        @(negedge CLK);
        bus.req_valid = 2'b00;
        check({v.name, "_issue"},
              {bus.alu_inp_valid, bus.alu_ce, bus.alu_mode, bus.alu_cin, bus.alu_cmd, bus.alu_opa, bus.alu_opb},
              {2'b11, 1'b1, v.mode, v.cin, v.cmd, v.a, v.b});
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus.rsp_valid != 2'b00) break;
            w++;
            if (bus.alu_ce) ce_extra++;
        end
        check({v.name, "_wait_cycles"}, w, v.lat);
        check({v.name, "_extra_ce"}, ce_extra, 0);
        check({v.name, "_rsp_valid"}, bus.rsp_valid, 2'b01 << v.r);
        check({v.name, "_rsp_res"}, bus.rsp_res, v.res);
        check({v.name, "_rsp_flags"}, bus.rsp_flags, v.flags);
        @(negedge CLK);
        check({v.name, "_idle_after"}, {bus.busy, bus.rsp_valid}, 3'b000);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin : main
        int grants[4];
        int gcnt, rcnt, last, saw_rsp;
        int gcyc[4];

        vecs[0] = '{0, 4'd0,  1'b1, 1'b0, 8'hF0, 8'h20, 9'h110, 6'b001000, 1, "add"};
        vecs[1] = '{1, 4'd9,  1'b1, 1'b0, 8'h03, 8'h04, 9'h00C, 6'b000000, 2, "mul9"};
        vecs[2] = '{0, 4'd10, 1'b1, 1'b0, 8'h05, 8'h07, 9'h023, 6'b000000, 2, "mul10"};
        vecs[3] = '{1, 4'd9,  1'b0, 1'b0, 8'hCC, 8'hAA, 9'h088, 6'b000000, 1, "mode0_cmd9"};
        vecs[4] = '{0, 4'd2,  1'b1, 1'b1, 8'hFF, 8'h00, 9'h100, 6'b001000, 1, "addc"};
        vecs[5] = '{1, 4'd8,  1'b1, 1'b0, 8'h05, 8'h09, 9'h000, 6'b000010, 1, "cmp"};
        vecs[6] = '{0, 4'd15, 1'b1, 1'b0, 8'h12, 8'h34, 9'h000, 6'b100000, 1, "err"};

        bus.req_valid = 2'b00;
        bus.req_cmd   = '0;
        bus.req_mode  = '0;
        bus.req_cin   = '0;
        bus.req_opa   = '0;
        bus.req_opb   = '0;
        bus.rsp_ready = 2'b00;

        // Reset state, with requests pending to show nothing is accepted under reset.
        #2 RST = 1'b0;
        #1 bus.req_valid = 2'b11;
        #1;
        check("reset_req_ready", bus.req_ready, 2'b00);
        check("reset_outputs",
              {bus.busy, bus.alu_ce, bus.alu_inp_valid, bus.alu_mode, bus.alu_cin, bus.alu_cmd,
               bus.alu_opa, bus.alu_opb, bus.rsp_valid, bus.rsp_res, bus.rsp_flags}, 0);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Contention from reset: grants must alternate 0,1,0,1.
        pulse_reset();
        set_slot(0, 4'd0, 1'b1, 1'b0, 8'd1, 8'd2);
        set_slot(1, 4'd0, 1'b1, 1'b0, 8'd10, 8'd20);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        gcnt = 0; rcnt = 0; last = 0;
        for (int k = 0; k < 60 && rcnt < 4; k++) begin
            #1;
            if (bus.req_ready != 2'b00 && gcnt < 4) begin
                last = int'(bus.req_ready[1]);
                grants[gcnt] = last;
                gcnt++;
            end
            if (bus.rsp_valid != 2'b00) begin
                check("cont_rsp_valid", bus.rsp_valid, 2'b01 << last);
                check("cont_rsp_res", bus.rsp_res, (last == 1) ? 9'd30 : 9'd3);
                rcnt++;
                if (rcnt == 4) bus.req_valid = 2'b00;
            end
            @(negedge CLK);
        end
        bus.req_valid = 2'b00;
        check("cont_rsp_count", rcnt, 4);
        for (int i = 0; i < gcnt; i++) check("cont_grant_order", grants[i], i % 2);
        wait_idle("cont_idle");

        // Backpressure: non-owner rsp_ready must be ignored; both requesters pending.
        @(negedge CLK);
        set_slot(0, 4'd0, 1'b1, 1'b0, 8'hF0, 8'h20);
        set_slot(1, 4'd0, 1'b1, 1'b0, 8'd1, 8'd1);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b10;
        #1 check("bp_ready", bus.req_ready, 2'b01);
        @(negedge CLK);
        bus.req_valid = 2'b11;
        saw_rsp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus.rsp_valid != 2'b00) begin saw_rsp = 1; break; end
        end
        check("bp_rsp_seen", saw_rsp, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold",
                  {bus.rsp_valid, bus.rsp_res, bus.rsp_flags, bus.req_ready, bus.alu_ce},
                  {2'b01, 9'h110, 6'b001000, 2'b00, 1'b0});
            @(negedge CLK);
        end
        bus.rsp_ready = 2'b01;
        @(negedge CLK);
        check("bp_idle_busy", bus.busy, 1'b0);
        check("bp_ptr_moved", bus.req_ready, 2'b10);
        bus.req_valid = 2'b00;
        #1 check("bp_drop_ready", bus.req_ready, 2'b00);
        @(negedge CLK);
        check("bp_drop_no_grant", bus.busy, 1'b0);

        // Reset during WAIT of a multiply from requester 1.
        set_slot(1, 4'd9, 1'b1, 1'b0, 8'd3, 8'd4);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b11;
        #1 check("rst_ready", bus.req_ready, 2'b10);
        @(negedge CLK);
        bus.req_valid = 2'b00;
        @(negedge CLK);
        check("rst_in_wait", {bus.busy, bus.alu_ce}, 2'b10);
        RST = 1'b0;
        #1;
        check("rst_mid_outputs",
              {bus.busy, bus.alu_ce, bus.alu_inp_valid, bus.alu_mode, bus.alu_cmd,
               bus.alu_opa, bus.alu_opb, bus.rsp_valid, bus.req_ready}, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        saw_rsp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (bus.rsp_valid != 2'b00 || bus.busy) saw_rsp = 1;
        end
        check("rst_no_rsp", saw_rsp, 0);
        set_slot(0, 4'd0, 1'b1, 1'b0, 8'd1, 8'd2);
        bus.req_valid = 2'b11;
        #1 check("rst_first_grant", bus.req_ready, 2'b01);
        @(negedge CLK);
        bus.req_valid = 2'b00;
        wait_idle("rst_done_idle");

        // Streaming from requester 1 alone with the pointer at 0.
        pulse_reset();
        set_slot(1, 4'd0, 1'b1, 1'b0, 8'd10, 8'd20);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b11;
        gcnt = 0;
        for (int k = 0; k < 40 && gcnt < 4; k++) begin
            #1;
            if (bus.req_ready == 2'b10) begin
                gcyc[gcnt] = cyc;
                gcnt++;
            end
            if (bus.rsp_valid != 2'b00)
                check("stream_rsp", {bus.rsp_valid, bus.rsp_res}, {2'b10, 9'd30});
            @(negedge CLK);
        end
        bus.req_valid = 2'b00;
        check("stream_grants", gcnt, 4);
        for (int i = 1; i < gcnt; i++) check("stream_spacing", gcyc[i] - gcyc[i-1], 4);
        wait_idle("stream_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
